// File: rtl/spi_fsm.sv
// SPI slave transaction controller.
// Sequences one address byte (with the R/W flag in its MSB) followed by one
// data byte. The enables for the address latch, shift-register load, data
// memory write and MISO buffer are pure functions of the state. They are
// registered together with the state, so each one changes one clk after the
// condition that caused it.
module spi_fsm #(
    parameter int width = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipSelect,
    input  logic       sclkPosEdge,
    input  logic       srMsb,
    output logic       addrWe,
    output logic       srWe,
    output logic       dmWe,
    output logic       misoBufe,
    output logic       overrun,
    output logic [2:0] state
);

    localparam int CW = $clog2(width);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GET_ADDR    = 3'd1,
        GOT_ADDR    = 3'd2,
        READ_LOAD   = 3'd3,
        READ_SEND   = 3'd4,
        WRITE_RECV  = 3'd5,
        WRITE_STORE = 3'd6,
        DONE        = 3'd7
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            overrun_reg, overrun_next;
    logic            addr_we_reg, sr_we_reg, dm_we_reg, miso_bufe_reg;

    // Only the three shifting states count SCLK edges; in every other
    // state a stray edge is ignored.
    logic counting;
    logic last_edge;
    assign counting  = (state_reg == GET_ADDR) || (state_reg == READ_SEND) ||
                       (state_reg == WRITE_RECV);
    assign last_edge = sclkPosEdge && (count_reg == LAST);

    // Next-state, bit-counter and overrun-flag logic. Chip-select release
    // takes priority over SCLK edges.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        overrun_next = overrun_reg;
        if (state_reg != IDLE && chipSelect) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!chipSelect) begin
                        state_next   = GET_ADDR;
                        overrun_next = 1'b0;
                    end
                end
                GET_ADDR:    if (last_edge) state_next = GOT_ADDR;
                GOT_ADDR:    state_next = srMsb ? READ_LOAD : WRITE_RECV;
                READ_LOAD:   state_next = READ_SEND;
                READ_SEND:   if (last_edge) state_next = DONE;
                WRITE_RECV:  if (last_edge) state_next = WRITE_STORE;
                WRITE_STORE: state_next = DONE;
                DONE:        if (sclkPosEdge) overrun_next = 1'b1;
                default:     state_next = IDLE;
            endcase
            if (counting && sclkPosEdge && !last_edge) begin
                count_next = count_reg + CW'(1);
            end
        end
        // Each new state starts its bit count from zero.
        if (state_next != state_reg) begin
            count_next = '0;
        end
    end

    // State, counter, sticky flag and the state-decoded enables.
    // The enables are decoded from the next state, so they always match
    // the state register they are registered alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            overrun_reg   <= 1'b0;
            addr_we_reg   <= 1'b0;
            sr_we_reg     <= 1'b0;
            dm_we_reg     <= 1'b0;
            miso_bufe_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            overrun_reg   <= overrun_next;
            addr_we_reg   <= (state_next == GOT_ADDR);
            sr_we_reg     <= (state_next == READ_LOAD);
            dm_we_reg     <= (state_next == WRITE_STORE);
            miso_bufe_reg <= (state_next == READ_SEND);
        end
    end

    assign addrWe   = addr_we_reg;
    assign srWe     = sr_we_reg;
    assign dmWe     = dm_we_reg;
    assign misoBufe = miso_bufe_reg;
    assign overrun  = overrun_reg;
    assign state    = state_reg;

endmodule

// File: tb/tb_spi_fsm.sv
// Testbench for spi_fsm. A width=4 instance is checked against a table of
// per-cycle vectors. A width=8 instance is checked by hand-written
// multi-cycle transaction sequences. Both instances share the same inputs.
module tb_spi_fsm;

    logic clk = 1'b0;
    logic reset, chipSelect, sclkPosEdge, srMsb;

    logic       addrWe8, srWe8, dmWe8, misoBufe8, overrun8;
    logic [2:0] state8;
    logic       addrWe4, srWe4, dmWe4, misoBufe4, overrun4;
    logic [2:0] state4;

    int tests = 0;
    int fails = 0;
    int dm_cnt, addr_cnt, sr_cnt, miso_pulses;

    always #5 clk = ~clk;

    spi_fsm #(.width(8)) dut8 (
        .clk(clk), .reset(reset), .chipSelect(chipSelect),
        .sclkPosEdge(sclkPosEdge), .srMsb(srMsb),
        .addrWe(addrWe8), .srWe(srWe8), .dmWe(dmWe8),
        .misoBufe(misoBufe8), .overrun(overrun8), .state(state8)
    );

    spi_fsm #(.width(4)) dut4 (
        .clk(clk), .reset(reset), .chipSelect(chipSelect),
        .sclkPosEdge(sclkPosEdge), .srMsb(srMsb),
        .addrWe(addrWe4), .srWe(srWe4), .dmWe(dmWe4),
        .misoBufe(misoBufe4), .overrun(overrun4), .state(state4)
    );

    typedef struct {
        logic       r, c, p, m;
        logic [2:0] st;
        logic [4:0] outs;   // {addrWe, srWe, dmWe, misoBufe, overrun}
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic c, input logic p,
                                input logic m, input logic [2:0] st,
                                input logic [4:0] outs);
        vec_t v;
        v.r = r; v.c = c; v.p = p; v.m = m; v.st = st; v.outs = outs;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // One clk cycle: drive the inputs, wait for the edge, then sample 1 time
    // unit later. The width-8 enable activity is accumulated as it goes.
    task automatic step(input logic r, input logic c, input logic p, input logic m);
        reset = r; chipSelect = c; sclkPosEdge = p; srMsb = m;
        if (p && misoBufe8 === 1'b1) miso_pulses++;
        @(posedge clk);
        #1;
        if (dmWe8)   dm_cnt++;
        if (addrWe8) addr_cnt++;
        if (srWe8)   sr_cnt++;
    endtask

    // n SCLK pulses, each followed by two quiet clks (master spacing).
    task automatic pulses(input int n, input logic m);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b1, m);
            step(1'b0, 1'b0, 1'b0, m);
            step(1'b0, 1'b0, 1'b0, m);
        end
    endtask

    task automatic clear_counts();
        dm_cnt = 0; addr_cnt = 0; sr_cnt = 0; miso_pulses = 0;
    endtask

    function automatic int outs8();
        return {addrWe8, srWe8, dmWe8, misoBufe8, overrun8};
    endfunction

    initial begin
        reset = 1'b1; chipSelect = 1'b1; sclkPosEdge = 1'b0; srMsb = 1'b0;
        clear_counts();

        // width=4 vectors: r, c, p, m, state, {addrWe,srWe,dmWe,miso,ovr}
        vq.push_back(mk(1,1,0,0, 3'd0, 5'b00000)); // reset
        vq.push_back(mk(0,0,0,0, 3'd1, 5'b00000)); // cs low -> GET_ADDR
        vq.push_back(mk(0,0,1,0, 3'd1, 5'b00000));
        vq.push_back(mk(0,0,1,0, 3'd1, 5'b00000));
        vq.push_back(mk(0,0,1,0, 3'd1, 5'b00000));
        vq.push_back(mk(0,0,1,0, 3'd2, 5'b10000)); // 4th pulse -> GOT_ADDR
        vq.push_back(mk(0,0,0,0, 3'd5, 5'b00000)); // write
        vq.push_back(mk(0,0,1,0, 3'd5, 5'b00000));
        vq.push_back(mk(0,0,1,0, 3'd5, 5'b00000));
        vq.push_back(mk(0,0,1,0, 3'd5, 5'b00000));
        vq.push_back(mk(0,0,1,0, 3'd6, 5'b00100)); // dmWe one clk
        vq.push_back(mk(0,0,0,0, 3'd7, 5'b00000));
        vq.push_back(mk(0,0,1,0, 3'd7, 5'b00001)); // overrun
        vq.push_back(mk(0,1,0,0, 3'd0, 5'b00001)); // held into IDLE
        vq.push_back(mk(0,0,0,0, 3'd1, 5'b00000)); // cleared on new txn
        vq.push_back(mk(0,0,1,1, 3'd1, 5'b00000));
        vq.push_back(mk(0,0,1,1, 3'd1, 5'b00000));
        vq.push_back(mk(0,0,1,1, 3'd1, 5'b00000));
        vq.push_back(mk(0,0,1,1, 3'd2, 5'b10000));
        vq.push_back(mk(0,0,1,1, 3'd3, 5'b01000)); // pulse in GOT_ADDR ignored
        vq.push_back(mk(0,0,1,1, 3'd4, 5'b00010)); // pulse in READ_LOAD ignored
        vq.push_back(mk(0,0,1,1, 3'd4, 5'b00010));
        vq.push_back(mk(0,0,1,1, 3'd4, 5'b00010));
        vq.push_back(mk(0,0,1,1, 3'd4, 5'b00010));
        vq.push_back(mk(0,0,1,1, 3'd7, 5'b00000)); // 4th counted pulse -> DONE
        vq.push_back(mk(0,1,0,0, 3'd0, 5'b00000));
        vq.push_back(mk(0,1,1,0, 3'd0, 5'b00000)); // cs high beats pulse
        vq.push_back(mk(0,0,0,0, 3'd1, 5'b00000));
        vq.push_back(mk(0,1,0,0, 3'd0, 5'b00000)); // 0->1->0 toggle
        vq.push_back(mk(0,0,0,0, 3'd1, 5'b00000));
        vq.push_back(mk(0,0,1,0, 3'd1, 5'b00000)); // fresh count
        vq.push_back(mk(0,0,1,0, 3'd1, 5'b00000));
        vq.push_back(mk(0,0,1,0, 3'd1, 5'b00000));
        vq.push_back(mk(0,0,1,0, 3'd2, 5'b10000));
        vq.push_back(mk(0,1,0,0, 3'd0, 5'b00000)); // abort from GOT_ADDR

        foreach (vq[i]) begin
            step(vq[i].r, vq[i].c, vq[i].p, vq[i].m);
            check($sformatf("w4 vec%0d state", i), int'(state4), int'(vq[i].st));
            check($sformatf("w4 vec%0d outs", i),
                  int'({addrWe4, srWe4, dmWe4, misoBufe4, overrun4}), int'(vq[i].outs));
        end

        // width=8 write transaction
        step(1,1,0,0);
        check("w8 reset state", int'(state8), 0);
        check("w8 reset outs", outs8(), 0);
        step(0,0,0,0);
        clear_counts();
        pulses(8, 1'b0);
        pulses(8, 1'b0);
        check("w8 write state", int'(state8), 7);
        check("w8 write addrWe clks", addr_cnt, 1);
        check("w8 write dmWe clks", dm_cnt, 1);
        check("w8 write srWe clks", sr_cnt, 0);

        // overrun on a 9th data pulse
        pulses(1, 1'b0);
        check("w8 overrun set", int'(overrun8), 1);
        step(0,1,0,0);
        check("w8 overrun held state", int'(state8), 0);
        check("w8 overrun held", int'(overrun8), 1);
        step(0,0,0,0);
        check("w8 overrun cleared", int'(overrun8), 0);
        check("w8 new txn state", int'(state8), 1);

        // width=8 read transaction
        clear_counts();
        pulses(8, 1'b1);
        pulses(8, 1'b1);
        check("w8 read state", int'(state8), 7);
        check("w8 read miso off", int'(misoBufe8), 0);
        check("w8 read miso pulses", miso_pulses, 8);
        check("w8 read addrWe clks", addr_cnt, 1);
        check("w8 read srWe clks", sr_cnt, 1);

        // abort after 5 data pulses of a write
        step(0,1,0,0);
        step(0,0,0,0);
        clear_counts();
        pulses(8, 1'b0);
        pulses(5, 1'b0);
        check("w8 abort pre state", int'(state8), 5);
        step(0,1,0,0);
        check("w8 abort state", int'(state8), 0);
        step(0,1,0,0);
        step(0,1,0,0);
        check("w8 abort dmWe clks", dm_cnt, 0);

        // reset during READ_SEND
        step(0,0,0,0);
        pulses(8, 1'b1);
        pulses(3, 1'b1);
        check("w8 rd mid state", int'(state8), 4);
        check("w8 rd mid miso", int'(misoBufe8), 1);
        step(1,0,0,0);
        check("w8 rd reset state", int'(state8), 0);
        check("w8 rd reset outs", outs8(), 0);
        step(0,0,0,0);
        check("w8 rd after reset state", int'(state8), 1);

        // reset during WRITE_RECV
        clear_counts();
        pulses(8, 1'b0);
        pulses(2, 1'b0);
        check("w8 wr mid state", int'(state8), 5);
        step(1,0,0,0);
        check("w8 wr reset state", int'(state8), 0);
        step(0,0,0,0);
        check("w8 wr after reset state", int'(state8), 1);
        step(0,0,0,0);
        step(0,0,0,0);
        check("w8 wr reset dmWe clks", dm_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
